mu2cgra_buffer: RTL and testbench

Elastic output buffer between the MatrixUnit systolic-array output port and the CGRA `mu2cgra` input. It accepts 512-bit result beats under valid/ready and stores up to DEPTH beats. It re-presents each beat to the CGRA as LANES independent 16-bit lanes under valid/ready, and counts delivered beats so it can signal tile completion. It decouples CGRA back-pressure from the systolic array so array drain does not stall on single-cycle CGRA hiccups.

---
 rtl/mu2cgra_buffer.sv | 108 ++++++++++
 tb/tb_mu2cgra_buffer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu2cgra_buffer.sv
// Elastic FIFO between the MatrixUnit output port and the CGRA mu2cgra input.
// Stores DEPTH 512-bit beats, presents the head beat as lanes, and counts pops for tile completion.
module mu2cgra_buffer #(
    parameter int unsigned LANES  = 32,
    parameter int unsigned LANE_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      flush,
    input  logic                      mu_valid,
    output logic                      mu_ready,
    input  logic [LANES*LANE_W-1:0]   mu_data,
    output logic                      mu2cgra_valid,
    input  logic                      cgra2mu_ready,
    output logic [LANE_W-1:0]         mu2cgra [LANES-1:0],
    input  logic [CNT_W-1:0]          beats_expected,
    output logic                      tile_done,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam logic [OW-1:0] OccFull = OW'(DEPTH);

    logic [LANES*LANE_W-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]           occ_q, occ_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    tile_done_q, tile_done_d;
    logic                    push, pop;
    logic [LANES*LANE_W-1:0] head;

    // Ready never looks at the downstream side, so no combinational ready path exists.
    assign mu_ready      = !reset_in && !flush && (occ_q < OccFull);
    assign mu2cgra_valid = (occ_q != '0);
    assign push          = mu_valid && mu_ready;
    assign pop           = mu2cgra_valid && cgra2mu_ready && !flush;
    assign occupancy     = occ_q;
    assign tile_done     = tile_done_q;
    assign head          = mem[rd_ptr_q];
    assign cnt_inc       = cnt_q + CNT_W'(1);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        cnt_d       = cnt_q;
        tile_done_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                if ((beats_expected != '0) && (cnt_inc == beats_expected)) begin
                    cnt_d       = '0;
                    tile_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            cnt_q       <= '0;
            tile_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            cnt_q       <= cnt_d;
            tile_done_q <= tile_done_d;
        end
    end

    // Storage needs no reset: the output is masked whenever the buffer is empty.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr_q] <= mu_data;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mu2cgra[i] = mu2cgra_valid ? head[i*LANE_W +: LANE_W] : '0;
        end
    end

endmodule

// File: tb/tb_mu2cgra_buffer.sv
// Directed self-checking bench for mu2cgra_buffer (LANES=32, LANE_W=16, DEPTH=4).
module tb_mu2cgra_buffer;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        flush;
    logic        mu_valid;
    logic        mu_ready;
    logic [511:0] mu_data;
    logic        mu2cgra_valid;
    logic        cgra2mu_ready;
    logic [15:0] mu2cgra [31:0];
    logic [15:0] beats_expected;
    logic        tile_done;
    logic [2:0]  occupancy;
    logic [511:0] out_flat;

    int tests_run    = 0;
    int tests_failed = 0;

    mu2cgra_buffer #(
        .LANES(32), .LANE_W(16), .DEPTH(4), .CNT_W(16)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .flush          (flush),
        .mu_valid       (mu_valid),
        .mu_ready       (mu_ready),
        .mu_data        (mu_data),
        .mu2cgra_valid  (mu2cgra_valid),
        .cgra2mu_ready  (cgra2mu_ready),
        .mu2cgra        (mu2cgra),
        .beats_expected (beats_expected),
        .tile_done      (tile_done),
        .occupancy      (occupancy)
    );

    always #5 clk_in = ~clk_in;

    always_comb begin
        out_flat = '0;
        for (int i = 0; i < 32; i++) out_flat[i*16 +: 16] = mu2cgra[i];
    end

    // Lane i of beat n carries n*32+i.
    function automatic logic [511:0] make_beat(input int n);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) b[i*16 +: 16] = 16'(n * 32 + i);
        return b;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Streams n beats with ready high; td[c] is tile_done after edge c (pop of beat j at edge j+1).
    task automatic deliver(input int n, input int base, output logic [15:0] td);
        td = '0;
        cgra2mu_ready = 1'b1;
        for (int c = 0; c < n + 3; c++) begin
            mu_valid = (c < n);
            mu_data  = make_beat(base + c);
            step();
            td[c] = tile_done;
        end
        mu_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b1; flush = 1'b0; mu_valid = 1'b0; mu_data = '0;
        cgra2mu_ready = 1'b0; beats_expected = '0;
        #12;
        tests_run++;
        if (mu_ready !== 1'b0 || mu2cgra_valid !== 1'b0 || tile_done !== 1'b0 ||
            occupancy !== 3'd0 || out_flat !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: ready=%b valid=%b done=%b occ=%0d lanes=%0h expected 0 0 0 0 0",
                     mu_ready, mu2cgra_valid, tile_done, occupancy, out_flat);
        end
        @(posedge clk_in); #1;
        reset_in = 1'b0;
        #1;
        tests_run++;
        if (mu_ready !== 1'b1 || mu2cgra_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b valid=%b expected 1 0", mu_ready, mu2cgra_valid);
        end
    endtask

    task automatic test_single_beat();
        cgra2mu_ready = 1'b1;
        mu_valid = 1'b1;
        mu_data  = make_beat(0);
        step();
        mu_valid = 1'b0;
        tests_run++;
        if (mu2cgra_valid !== 1'b1 || occupancy !== 3'd1 || out_flat !== make_beat(0)) begin
            tests_failed++;
            $display("FAIL single_beat: valid=%b occ=%0d lanes=%0h expected 1 1 %0h",
                     mu2cgra_valid, occupancy, out_flat, make_beat(0));
        end
        step();
        tests_run++;
        if (occupancy !== 3'd0 || mu2cgra_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: occ=%0d valid=%b expected 0 0", occupancy, mu2cgra_valid);
        end
    endtask

    task automatic test_fill_backpressure();
        logic exp_rdy;
        logic acc;
        cgra2mu_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mu_valid = 1'b1;
            mu_data  = make_beat(10 + k);
            #1;
            exp_rdy = (k < 4);
            tests_run++;
            if (mu_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL fill_ready_%0d: got %b expected %b", k, mu_ready, exp_rdy);
            end
            step();
        end
        tests_run++;
        if (occupancy !== 3'd4) begin
            tests_failed++;
            $display("FAIL fill_occ: got %0d expected 4", occupancy);
        end
        // Fifth beat stays on the bus until the buffer frees an entry.
        cgra2mu_ready = 1'b1;
        #1;
        tests_run++;
        if (mu_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_pop_ready: got %b expected 0", mu_ready);
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (mu2cgra_valid !== 1'b1 || out_flat !== make_beat(10 + k)) begin
                tests_failed++;
                $display("FAIL drain_beat_%0d: valid=%b lanes=%0h expected 1 %0h",
                         k, mu2cgra_valid, out_flat, make_beat(10 + k));
            end
            acc = mu_valid && mu_ready;
            step();
            if (acc) mu_valid = 1'b0;
        end
        tests_run++;
        if (occupancy !== 3'd0 || mu_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_end: occ=%0d pending=%b expected 0 0", occupancy, mu_valid);
        end
    endtask

    task automatic test_streaming();
        int bad = 0;
        int first_bad = -1;
        cgra2mu_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            mu_valid = 1'b1;
            mu_data  = make_beat(100 + n);
            step();
            if (occupancy !== 3'd1 || out_flat !== make_beat(100 + n) || mu_ready !== 1'b1) begin
                bad++;
                if (first_bad < 0) first_bad = n;
            end
        end
        mu_valid = 1'b0;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL streaming: %0d bad cycles (first at beat %0d), required 0", bad, first_bad);
        end
        step();
        tests_run++;
        if (occupancy !== 3'd0) begin
            tests_failed++;
            $display("FAIL stream_drain: occ=%0d expected 0", occupancy);
        end
    endtask

    task automatic test_tile_tracking();
        logic [15:0] td;
        // Zero the counter left over from untracked traffic before changing beats_expected.
        flush = 1'b1;
        #1;
        tests_run++;
        if (mu_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_ready: got %b expected 0", mu_ready);
        end
        step();
        flush = 1'b0;
        beats_expected = 16'd3;
        deliver(7, 300, td);
        tests_run++;
        if (td !== 16'b0000_0000_0100_1000) begin
            tests_failed++;
            $display("FAIL tile_pulses_7: got %b expected %b", td, 16'b0000_0000_0100_1000);
        end
        // Counter should now sit at 1, so two more beats complete the next tile.
        deliver(2, 310, td);
        tests_run++;
        if (td !== 16'b0000_0000_0000_0100) begin
            tests_failed++;
            $display("FAIL tile_residual: got %b expected %b", td, 16'b0000_0000_0000_0100);
        end
    endtask

    task automatic test_flush();
        logic [15:0] td;
        deliver(2, 320, td);
        tests_run++;
        if (td !== 16'b0) begin
            tests_failed++;
            $display("FAIL flush_prefill_done: got %b expected 0", td);
        end
        cgra2mu_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mu_valid = 1'b1;
            mu_data  = make_beat(330 + k);
            step();
        end
        tests_run++;
        if (occupancy !== 3'd2) begin
            tests_failed++;
            $display("FAIL flush_setup_occ: got %0d expected 2", occupancy);
        end
        // This pop would finish a tile if it were counted.
        mu_data = make_beat(340);
        cgra2mu_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        mu_valid = 1'b0;
        tests_run++;
        if (occupancy !== 3'd0 || mu2cgra_valid !== 1'b0 || tile_done !== 1'b0 ||
            out_flat !== '0) begin
            tests_failed++;
            $display("FAIL flush_clear: occ=%0d valid=%b done=%b lanes=%0h expected 0 0 0 0",
                     occupancy, mu2cgra_valid, tile_done, out_flat);
        end
        deliver(3, 350, td);
        tests_run++;
        if (td !== 16'b0000_0000_0000_1000) begin
            tests_failed++;
            $display("FAIL flush_counter: got %b expected %b", td, 16'b0000_0000_0000_1000);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] td;
        deliver(1, 360, td);
        cgra2mu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mu_valid = 1'b1;
            mu_data  = make_beat(370 + k);
            step();
        end
        mu_valid = 1'b0;
        #2;
        reset_in = 1'b1;
        #1;
        tests_run++;
        if (mu2cgra_valid !== 1'b0 || occupancy !== 3'd0 || out_flat !== '0 ||
            mu_ready !== 1'b0 || tile_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b occ=%0d ready=%b done=%b lanes=%0h expected 0 0 0 0 0",
                     mu2cgra_valid, occupancy, mu_ready, tile_done, out_flat);
        end
        step();
        reset_in = 1'b0;
        #1;
        tests_run++;
        if (mu_ready !== 1'b1 || mu2cgra_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: ready=%b valid=%b expected 1 0", mu_ready, mu2cgra_valid);
        end
        cgra2mu_ready = 1'b1;
        mu_valid = 1'b1;
        mu_data  = make_beat(500);
        step();
        mu_valid = 1'b0;
        tests_run++;
        if (out_flat !== make_beat(500) || occupancy !== 3'd1) begin
            tests_failed++;
            $display("FAIL post_reset_data: lanes=%0h occ=%0d expected %0h 1",
                     out_flat, occupancy, make_beat(500));
        end
        step();
        // Counter restarted at 0: the beat above plus two more make a tile.
        deliver(2, 510, td);
        tests_run++;
        if (td !== 16'b0000_0000_0000_0100) begin
            tests_failed++;
            $display("FAIL post_reset_counter: got %b expected %b", td, 16'b0000_0000_0000_0100);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_fill_backpressure();
        test_streaming();
        test_tile_tracking();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
